complex_beat_gatherer: RTL
==========================

Name: complex_beat_gatherer

Overview:
- Parametrised deserialiser: gathers no_of_beats consecutive input beats, each element_width*no_of_units bits, into one wide output word.
- Successor to the two-beat decoder-side packer. Adds:
  - configurable beat count and fill order
  - valid/ready handshakes on both sides
  - a single output holding slot, so gathering continues while the consumer stalls
  - flush of a partially filled word
- Sits between the per-unit complex datapath and the wide consumer/memory writer.

Parameters:
- no_of_units, 4, complex units per beat
- element_width, 64, bits per unit element
- no_of_beats, 2, beats per output word; legal range 2..16
- lsb_first, 1, 1 = first beat lands in bits [BW-1:0]; 0 = first beat lands in the top slice
- BW (derived) = element_width*no_of_units; OW (derived) = BW*no_of_beats; CW (derived) = clog2(no_of_beats+1)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in  input  BW  input beat data
- in_valid  input  1  beat present
- in_ready  output  1  gatherer can accept a beat this cycle
- flush  input  1  single-cycle request to emit the current partial word
- out  output  OW  gathered word (holding slot)
- out_valid  output  1  holding slot occupied
- out_ready  input  1  consumer takes the word this cycle
- out_partial  output  1  word in slot came from a flush (not completely filled)
- out_beats  output  CW  number of valid beats in the word in slot
- beat_count  output  CW  beats currently in the accumulator

Behaviour:
- Reset (synchronous, on clk edge with rst=1) overrides all other inputs. Reset values:
  - out_valid=0, out_partial=0, out_beats=0, beat_count=0
  - accumulator=0, flush_pending=0, out=0
  - in_ready=1 from the first cycle after reset
- Reset mid-word discards accumulated beats and any held word; nothing is emitted.
- Handshakes:
  - in accept = in_valid & in_ready.
  - out transfer = out_valid & out_ready.
  - The producer holds in stable while in_valid=1 and in_ready=0.
- Fill order: beat k (0-based) goes to slice [k*BW +: BW] when lsb_first=1. When lsb_first=0 it goes to slice [(no_of_beats-1-k)*BW +: BW].
- State machine has two states:
  - FILL: accumulator not yet complete.
  - HOLD_FULL: accumulator complete while the slot is busy.
- Operation in FILL:
  - On accept, write the slice and increment beat_count.
  - On the beat where beat_count==no_of_beats-1:
    - If the slot is free, or out transfer happens the same cycle, load the full word into out next cycle. Set out_valid=1, out_partial=0, out_beats=no_of_beats, beat_count=0.
    - Otherwise keep the beat in the accumulator and go to HOLD_FULL.
- HOLD_FULL:
  - in_ready=0.
  - On out transfer, move the accumulator into the slot in the same edge, clear the accumulator, and return to FILL.
  - Zero-bubble back-to-back words are required.
- in_ready = !(state==HOLD_FULL) & !flush_pending. It is combinational from registers only, with no dependency on in_valid.
- Latency: the word is valid in out on the cycle after its last beat is accepted when the slot is free. Throughput is one beat per cycle with out_ready held high.
- Flush:
  - A flush asserted with an accepted beat in the same cycle includes that beat.
  - If the resulting count is 0, the flush is a no-op.
  - If the count is no_of_beats, the word is treated as a normal full word with out_partial=0.
  - Otherwise, when the slot is free or transferring, emit the partial word next cycle:
    - unfilled slices are zero
    - out_partial=1, out_beats=count
    - the accumulator is cleared
  - If the slot is busy, set flush_pending=1 and hold in_ready=0. Emit on the first cycle the slot is freed, then clear flush_pending.
  - A flush while flush_pending=1 is absorbed; there is no double emit.
- out is stable while out_valid=1 and out_ready=0. out keeps its last value after transfer; it is not cleared.
- beat_count never exceeds no_of_beats-1 in FILL. beat_count wraps to 0 on every emit.

Test Plan:
1. Defaults, lsb_first=1, out_ready=1. Send beats A,B on consecutive cycles -> one cycle after B, out={B,A}, out_valid=1 for 1 cycle, out_partial=0, out_beats=2. in_ready stays 1.
2. no_of_beats=4, lsb_first=0, out_ready=0. Send 8 beats D0..D7 -> slot = {D0,D1,D2,D3}. D4..D7 are accepted and the bench sees in_ready=0 after D7. Raise out_ready for 1 cycle -> next cycle out={D4,D5,D6,D7}, with no idle cycle between the words.
3. no_of_beats=4. Send 3 beats then pulse flush -> out={0,C2,C1,C0}, out_partial=1, out_beats=3, beat_count=0.
4. Slot busy (out_ready=0), 1 beat in accumulator, pulse flush -> flush_pending, in_ready=0. Raise out_ready -> the partial word follows the full word on the next cycle, then in_ready=1.
5. Flush with the accumulator empty and no in_valid -> no out_valid pulse. Flush on the same cycle as the last beat -> full word with out_partial=0.
6. Assert rst after 1 of 2 beats with a held word in the slot -> next cycle out_valid=0, beat_count=0, in_ready=1. New beats A,B -> out={B,A}, with no stale data.

Source files
------------

// File: rtl/complex_beat_gatherer.sv
// complex_beat_gatherer: gathers no_of_beats input beats of BW bits into one
// OW-bit word, with valid/ready on both sides, a single output holding slot,
// configurable fill order and flush of a partially filled word.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in, in_valid        input beat and its valid
//   in_ready            gatherer accepts a beat this cycle (from registers only)
//   flush               emit the current partial word
//   out, out_valid      holding slot contents and occupancy
//   out_ready           consumer takes the slot this cycle
//   out_partial         slot word came from a flush
//   out_beats           valid beats in the slot word
//   beat_count          beats currently in the accumulator
module complex_beat_gatherer #(
  parameter int unsigned no_of_units   = 4,
  parameter int unsigned element_width = 64,
  parameter int unsigned no_of_beats   = 2,
  parameter bit          lsb_first     = 1'b1,
  localparam int unsigned BW = element_width * no_of_units,
  localparam int unsigned OW = BW * no_of_beats,
  localparam int unsigned CW = $clog2(no_of_beats + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BW-1:0] in,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic [OW-1:0] out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_partial,
  output logic [CW-1:0] out_beats,
  output logic [CW-1:0] beat_count
);

  localparam logic [0:0] FILL      = 1'b0;
  localparam logic [0:0] HOLD_FULL = 1'b1;

  localparam logic [CW-1:0] NB    = CW'(no_of_beats);
  localparam logic [CW-1:0] NB_M1 = CW'(no_of_beats - 1);

  logic [0:0]    state_q, state_d;
  logic [OW-1:0] acc_q, acc_d, acc_w;
  logic [CW-1:0] cnt_q, cnt_d, cnt_w;
  logic          flush_pending_q, flush_pending_d;
  logic [OW-1:0] out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic          out_partial_q, out_partial_d;
  logic [CW-1:0] out_beats_q, out_beats_d;

  logic          accept;
  logic          xfer;
  logic          slot_free;
  logic          emit;
  logic [CW-1:0] slot_pos;

  // Ready depends only on registered state, never on in_valid.
  assign in_ready = (state_q != HOLD_FULL) & ~flush_pending_q;

  // Next-state and slot-load decision.
  always_comb begin
    accept          = in_valid & in_ready;
    xfer            = out_valid_q & out_ready;
    slot_free       = ~out_valid_q | out_ready;
    slot_pos        = lsb_first ? cnt_q : (NB_M1 - cnt_q);
    acc_w           = acc_q;
    cnt_w           = cnt_q;
    emit            = 1'b0;
    state_d         = state_q;
    flush_pending_d = flush_pending_q;
    out_d           = out_q;
    out_valid_d     = out_valid_q & ~out_ready;
    out_partial_d   = out_partial_q;
    out_beats_d     = out_beats_q;

    // Beat k lands in its slice; accept only happens in FILL with count < NB.
    if (accept) begin
      for (int unsigned k = 0; k < no_of_beats; k++) begin
        if (slot_pos == CW'(k)) acc_w[k*BW +: BW] = in;
      end
      cnt_w = cnt_q + CW'(1);
    end

    case (state_q)
      HOLD_FULL: begin
        if (xfer) begin
          emit    = 1'b1;
          state_d = FILL;
        end
      end
      default: begin
        if (flush_pending_q) begin
          // No beats are accepted while pending, so acc_w/cnt_w hold the partial word.
          if (slot_free) begin
            emit            = 1'b1;
            flush_pending_d = 1'b0;
          end
        end else if (cnt_w == NB) begin
          if (slot_free) emit = 1'b1;
          else           state_d = HOLD_FULL;
        end else if (flush && (cnt_w != '0)) begin
          if (slot_free) emit = 1'b1;
          else           flush_pending_d = 1'b1;
        end
      end
    endcase

    acc_d = acc_w;
    cnt_d = cnt_w;

    // Unfilled slices are already zero because the accumulator clears on every emit.
    if (emit) begin
      out_d         = acc_w;
      out_valid_d   = 1'b1;
      out_partial_d = (cnt_w != NB);
      out_beats_d   = cnt_w;
      acc_d         = '0;
      cnt_d         = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= FILL;
      acc_q           <= '0;
      cnt_q           <= '0;
      flush_pending_q <= 1'b0;
      out_q           <= '0;
      out_valid_q     <= 1'b0;
      out_partial_q   <= 1'b0;
      out_beats_q     <= '0;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      cnt_q           <= cnt_d;
      flush_pending_q <= flush_pending_d;
      out_q           <= out_d;
      out_valid_q     <= out_valid_d;
      out_partial_q   <= out_partial_d;
      out_beats_q     <= out_beats_d;
    end
  end

  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign out_partial = out_partial_q;
  assign out_beats   = out_beats_q;
  assign beat_count  = cnt_q;

endmodule
